// File: rtl/plugin_regs_pkg.sv
// Shared register map, bit positions and CTRL layout for the plugin RX FIFO bank.
package plugin_regs_pkg;

  // Word offsets in the plugin register window
  localparam int unsigned CTRL_W    = 0;
  localparam int unsigned STATUS_W  = 1;
  localparam int unsigned RXDATA_W  = 2;
  localparam int unsigned PEEK_W    = 3;
  localparam int unsigned DROPCNT_W = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_B    = 0;
  localparam int unsigned CTRL_IRQEN_B = 1;
  localparam int unsigned CTRL_FLUSH_B = 2;
  localparam int unsigned CTRL_THR_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STAT_EMPTY_B = 0;
  localparam int unsigned STAT_FULL_B  = 1;
  localparam int unsigned STAT_OVF_B   = 2;
  localparam int unsigned STAT_CNT_LSB = 16;

  localparam logic [15:0] DROPCNT_MAX = 16'hFFFF;

  // Persistent CTRL fields; flush is a pulse and is not stored
  typedef struct packed {
    logic [7:0] threshold;
    logic       irq_en;
    logic       enable;
  } ctrl_t;

  // Read-back image of CTRL (flush always reads 0)
  function automatic logic [31:0] ctrl_rd(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_B]                  = c.enable;
    w[CTRL_IRQEN_B]               = c.irq_en;
    w[CTRL_THR_LSB +: 8]          = c.threshold;
    return w;
  endfunction

endpackage

// File: rtl/plugin_sync_fifo.sv
// Single-clock FIFO with flush; a push while full is taken only alongside a pop.
module plugin_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  // Pointer/count update; flush discards any same-cycle push or pop
  always_ff @(posedge ACLK) begin
    if (!ARESETn || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not cleared; empty reads are masked by the consumer
  always_ff @(posedge ACLK) begin
    if (ARESETn && !flush && do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/plugin_rx_fifo_regs.sv
// Plugin RX register bank: CTRL/STATUS/RXDATA/PEEK/DROPCNT around a push-only FIFO.
module plugin_rx_fifo_regs
  import plugin_regs_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int WORD_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       rd_avalid_i,
  input  logic [WORD_ADDR_WIDTH-1:0] rd_word_addr_i,
  output logic [31:0]                rd_data_o,
  input  logic                       wr_valid_i,
  input  logic [WORD_ADDR_WIDTH-1:0] wr_word_addr_i,
  input  logic [31:0]                wr_data_i,
  input  logic [3:0]                 wr_strb_i,
  input  logic                       push_i,
  input  logic [31:0]                push_data_i,
  output logic                       irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ctrl_t          ctrl_q, ctrl_d;
  logic           ovf_q;
  logic [15:0]    dropcnt_q;
  logic [31:0]    head;
  logic [CW-1:0]  count, count_nxt;
  logic           full, empty;
  logic           wr_ctrl, wr_status, wr_dropcnt;
  logic           flush, pop, push_acc, drop, ovf_clr, drop_clr;
  logic           unused_ok;

  assign unused_ok = ^{wr_data_i[31:16], wr_data_i[7:3]};

  // Write decode
  assign wr_ctrl    = wr_valid_i && (wr_word_addr_i == WORD_ADDR_WIDTH'(CTRL_W));
  assign wr_status  = wr_valid_i && (wr_word_addr_i == WORD_ADDR_WIDTH'(STATUS_W));
  assign wr_dropcnt = wr_valid_i && (wr_word_addr_i == WORD_ADDR_WIDTH'(DROPCNT_W));
  assign flush      = wr_ctrl && wr_strb_i[0] && wr_data_i[CTRL_FLUSH_B];
  assign ovf_clr    = wr_status && wr_strb_i[0] && wr_data_i[STAT_OVF_B];
  assign drop_clr   = wr_dropcnt && (|wr_strb_i);

  // Stream side: reading RXDATA pops, a pop frees room for a push to a full FIFO
  assign pop       = rd_avalid_i && (rd_word_addr_i == WORD_ADDR_WIDTH'(RXDATA_W)) && !empty;
  assign push_acc  = push_i && ctrl_q.enable && (!full || pop);
  assign drop      = push_i && ctrl_q.enable && full && !pop && !flush;
  assign count_nxt = flush ? '0 : (count + CW'(push_acc) - CW'(pop));

  plugin_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .push      (push_acc),
    .push_data (push_data_i),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Next CTRL value with byte strobes applied
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl && wr_strb_i[0]) begin
      ctrl_d.enable = wr_data_i[CTRL_EN_B];
      ctrl_d.irq_en = wr_data_i[CTRL_IRQEN_B];
    end
    if (wr_ctrl && wr_strb_i[1]) ctrl_d.threshold = wr_data_i[CTRL_THR_LSB +: 8];
  end

  // CTRL register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) ctrl_q <= '0;
    else          ctrl_q <= ctrl_d;
  end

  // Sticky overflow; a new drop beats a same-cycle clear
  always_ff @(posedge ACLK) begin
    if (!ARESETn)     ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  // Saturating drop counter; a clear beats a same-cycle drop
  always_ff @(posedge ACLK) begin
    if (!ARESETn || drop_clr)              dropcnt_q <= '0;
    else if (drop && dropcnt_q != DROPCNT_MAX) dropcnt_q <= dropcnt_q + 16'd1;
  end

  // Threshold interrupt, looks at the post-edge count and CTRL
  always_ff @(posedge ACLK) begin
    if (!ARESETn) irq_o <= 1'b0;
    else          irq_o <= ctrl_d.irq_en && (ctrl_d.threshold != 8'd0) &&
                           (16'(count_nxt) >= 16'(ctrl_d.threshold));
  end

  // Combinational read mux
  always_comb begin
    rd_data_o = '0;
    case (rd_word_addr_i)
      WORD_ADDR_WIDTH'(CTRL_W):   rd_data_o = ctrl_rd(ctrl_q);
      WORD_ADDR_WIDTH'(STATUS_W): begin
        rd_data_o[STAT_EMPTY_B]        = empty;
        rd_data_o[STAT_FULL_B]         = full;
        rd_data_o[STAT_OVF_B]          = ovf_q;
        rd_data_o[STAT_CNT_LSB +: 16]  = 16'(count);
      end
      WORD_ADDR_WIDTH'(RXDATA_W),
      WORD_ADDR_WIDTH'(PEEK_W):   rd_data_o = empty ? '0 : head;
      WORD_ADDR_WIDTH'(DROPCNT_W): rd_data_o = {16'd0, dropcnt_q};
      default:                    rd_data_o = '0;
    endcase
  end

endmodule

// File: doc/plugin_rx_fifo_regs.md
# plugin_rx_fifo_regs

Register bank that sits directly downstream of the AXI word-read converter and alongside the word-write converter in the user plugin. It answers word reads combinationally on the read converter's `avalid`/`word_addr`/`data` port and accepts word writes from the write converter. It buffers a push-only data stream from plugin logic in a FIFO; reading the RXDATA word pops one entry. It also provides status, a saturating drop counter and a threshold interrupt.

## Interface
- `AXI4_DATA_WIDTH`, 32, data width; must be 32.
- `WORD_ADDR_WIDTH`, 4, word address width, matching the read converter.
- `FIFO_DEPTH`, 8, number of FIFO entries; power of two, 2..256.
- `ACLK`  in  1  clock.
- `ARESETn`  in  1  reset; synchronous and active-low.
- `rd_avalid_i`  in  1  read strobe from the read converter; data is sampled in the same cycle.
- `rd_word_addr_i`  in  WORD_ADDR_WIDTH  read word address.
- `rd_data_o`  out  32  read data; combinational from `rd_word_addr_i` and current state.
- `wr_valid_i`  in  1  write strobe, one cycle per write.
- `wr_word_addr_i`  in  WORD_ADDR_WIDTH  write word address.
- `wr_data_i`  in  32  write data.
- `wr_strb_i`  in  4  byte strobes.
- `push_i`  in  1  stream push; there is no backpressure.
- `push_data_i`  in  32  pushed word.
- `irq_o`  out  1  registered interrupt.

## Operation
- Word 0, CTRL (rw, byte strobes honoured):
  - [0] `enable`: pushes are ignored while 0.
  - [1] `irq_en`.
  - [2] `flush`: write-1, self-clearing, always reads 0.
  - [15:8] `threshold`.
- Word 1, STATUS (read-only except bit 2):
  - [0] empty, [1] full.
  - [2] overflow: sticky, write-1-to-clear.
  - [31:16] count, zero-extended.
- Word 2, RXDATA: read returns the head entry and pops it when `rd_avalid_i`=1 and the FIFO is non-empty. A read while empty returns 0 with no pop.
- Word 3, PEEK: returns the head entry (0 if empty); never pops.
- Word 4, DROPCNT: 16-bit saturating count of dropped pushes, zero-extended. Any write with any strobe clears it.
- All other words read 0; writes to them are ignored.
- Push handling:
  - A push with `enable`=1 and not full is accepted.
  - A push with `enable`=1 while full is also accepted if a pop occurs in the same cycle.
  - Otherwise a push with `enable`=1 is dropped: overflow is set and DROPCNT increments, saturating at 0xFFFF.
  - A push with `enable`=0 is ignored silently.
- Flush sets count to 0 and resets the pointers. A push or pop in the same cycle as the flush is discarded; no overflow or DROPCNT side effect results.
- Overflow W1C in the same cycle as a new drop: set wins. DROPCNT clear in the same cycle as a drop: the result is 0.
- `irq_o` is registered: `irq_en && count_next >= threshold && threshold != 0`.

## Timing
- Read data path: zero latency, combinational within the `rd_avalid_i` cycle.
- Pop effect: pointer and count update at the next `ACLK` edge.
- Push: an accepted push is visible in count/STATUS one cycle later and readable at RXDATA from that cycle onward.
- Write effects take hold at the next edge.
- `irq_o` asserts in the cycle after count reaches the threshold.
- Simultaneous push and pop: count is unchanged; pointers both advance modulo `FIFO_DEPTH`, with power-of-two wrap.
- Count width is `$clog2(FIFO_DEPTH+1)`. Full when count equals `FIFO_DEPTH`; empty when count is 0.
- Reset values:
  - CTRL = 0, count = 0, pointers = 0, overflow = 0, DROPCNT = 0.
  - `irq_o` = 0.
  - `rd_data_o` reflects reset state: STATUS reads 0x0000_0001; other words read 0.
- Reset mid-operation: FIFO contents are discarded and the next cycle matches post-reset state. Storage RAM need not be cleared; reads when empty mask it to 0.

## Structure
- `plugin_regs_pkg` holds:
  - word offsets `CTRL_W`, `STATUS_W`, `RXDATA_W`, `PEEK_W`, `DROPCNT_W`;
  - CTRL and STATUS bit positions;
  - `DROPCNT_MAX`.
- Sub-module `plugin_sync_fifo`:
  - parameters: width, depth.
  - ports: push, pop, flush, head, count, full, empty.
  - Accepts a push while full only when pop is also asserted.
- Top level holds CTRL, overflow, DROPCNT, the IRQ register, the read mux and the write decode.

## Test plan
- Reset, then read every word 0..15 → STATUS = 0x0000_0001, all other words = 0, `irq_o` = 0.
- Enable, push 0xA1, 0xB2, 0xC3 → STATUS = 0x0003_0000. PEEK reads 0xA1 twice. Three RXDATA reads return 0xA1, 0xB2, 0xC3. A fourth RXDATA read returns 0 and count stays 0.
- Depth 8: push 10 words with no reads → full, overflow = 1, DROPCNT = 2. W1C STATUS bit 2 → overflow = 0. Drain order matches push order, including pointer wrap.
- Full FIFO, push and RXDATA read in the same cycle → push accepted, count stays 8, no overflow.
- Threshold = 3, `irq_en` = 1: third push → `irq_o` = 1 on the following cycle. One pop → `irq_o` = 0 on the next cycle.
- Flush with a simultaneous push → count = 0 on the next cycle and DROPCNT is unchanged. Reset asserted mid-drain → all state returns to reset values.
